// File: rtl/rf_symbol_framer.sv
// RF correlator symbol framer: sync-word hunt, length byte, nibble-pair packing into a byte FIFO.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module rf_symbol_framer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       sync_found,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN_HI,
    ST_LEN_LO,
`ifdef CHECKSUM_EN
    ST_PAYLOAD,
    ST_CHK_HI,
    ST_CHK_LO
`else
    ST_PAYLOAD
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] hist_q, hist_d;
  logic [3:0]  len_hi_q, len_hi_d;
  logic [7:0]  rem_q, rem_d;
  logic [3:0]  nib_hi_q, nib_hi_d;
  logic        phase_q, phase_d;
  logic        sync_found_q, sync_found_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;
`ifdef CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
  logic [3:0]  chk_hi_q, chk_hi_d;
`endif

  logic        push_c;
  logic [7:0]  push_byte_c;
  logic [7:0]  len_c;

  logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          pop_c, full_c, write_c;

  // Framer FSM: only sym_valid cycles advance it
  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    len_hi_d     = len_hi_q;
    rem_d        = rem_q;
    nib_hi_d     = nib_hi_q;
    phase_d      = phase_q;
    sync_found_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    push_c       = 1'b0;
    push_byte_c  = {nib_hi_q, sym_in};
    len_c        = {len_hi_q, sym_in};
`ifdef CHECKSUM_EN
    chk_d        = chk_q;
    chk_hi_d     = chk_hi_q;
`endif
    if (sym_valid) begin
      case (state_q)
        ST_HUNT: begin
          if ({hist_q, sym_in} == SYNC_WORD) begin
            sync_found_d = 1'b1;
            state_d      = ST_LEN_HI;
          end
          hist_d = {hist_q[7:0], sym_in};
        end
        ST_LEN_HI: begin
          len_hi_d = sym_in;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (len_c == 8'h00) begin
            frame_err_d = 1'b1;
            hist_d      = 12'h000;
            state_d     = ST_HUNT;
          end else begin
            rem_d   = len_c;
            phase_d = 1'b0;
`ifdef CHECKSUM_EN
            chk_d   = 8'h00;
`endif
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!phase_q) begin
            nib_hi_d = sym_in;
            phase_d  = 1'b1;
          end else begin
            push_c  = 1'b1;
            phase_d = 1'b0;
            rem_d   = rem_q - 8'd1;
`ifdef CHECKSUM_EN
            // dropped bytes still count toward the checksum
            chk_d   = chk_q ^ push_byte_c;
            if (rem_q == 8'd1) state_d = ST_CHK_HI;
`else
            if (rem_q == 8'd1) begin
              frame_done_d = 1'b1;
              hist_d       = 12'h000;
              state_d      = ST_HUNT;
            end
`endif
          end
        end
`ifdef CHECKSUM_EN
        ST_CHK_HI: begin
          chk_hi_d = sym_in;
          state_d  = ST_CHK_LO;
        end
        ST_CHK_LO: begin
          if ({chk_hi_q, sym_in} == chk_q) frame_done_d = 1'b1;
          else                             frame_err_d  = 1'b1;
          hist_d  = 12'h000;
          state_d = ST_HUNT;
        end
`endif
        default: begin
          hist_d  = 12'h000;
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // Output FIFO; head byte and valid are registered from the next-state view
  always_comb begin
    pop_c      = byte_valid_q & byte_ready;
    full_c     = (count_q == CW'(FIFO_DEPTH));
    write_c    = push_c & (~full_c | pop_c);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (push_c & full_c & ~pop_c);
    if (write_c) begin
      mem_d[wr_ptr_q] = push_byte_c;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d      = count_q + CW'(write_c) - CW'(pop_c);
    byte_valid_d = (count_d != '0);
    byte_out_d   = byte_valid_d ? mem_d[rd_ptr_d] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      hist_q       <= '0;
      len_hi_q     <= '0;
      rem_q        <= '0;
      nib_hi_q     <= '0;
      phase_q      <= 1'b0;
      sync_found_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef CHECKSUM_EN
      chk_q        <= '0;
      chk_hi_q     <= '0;
`endif
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      len_hi_q     <= len_hi_d;
      rem_q        <= rem_d;
      nib_hi_q     <= nib_hi_d;
      phase_q      <= phase_d;
      sync_found_q <= sync_found_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
`ifdef CHECKSUM_EN
      chk_q        <= chk_d;
      chk_hi_q     <= chk_hi_d;
`endif
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign sync_found = sync_found_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
